// File: rtl/ad_fft_pkg.sv
// Shared types and default sizing for the ADC-to-FFT framing path.
// Used by ad_frame_ctrl and ad_clk_div.
package ad_fft_pkg;

    localparam int FFT_FRAME_LEN = 1024;
    localparam int AD_SAMPLE_DIV = 50;
    localparam int AD_DW         = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        DRAIN   = 2'd2
    } state_t;

endpackage

// File: rtl/ad_clk_div.sv
// Free-running sample divider: produces the ADC sample clock and a one-cycle
// sample tick on the last count of each period.
module ad_clk_div
    import ad_fft_pkg::*;
#(
    parameter int SAMPLE_DIV = AD_SAMPLE_DIV
) (
    input  logic clk,
    input  logic rst_n,
    output logic ad_clk,
    output logic tick
);

    localparam int CW = $clog2(SAMPLE_DIV);
    localparam logic [CW-1:0] CNT_LAST = CW'(SAMPLE_DIV - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(SAMPLE_DIV / 2);

    logic [CW-1:0] r_div_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_div_cnt <= '0;
        end else if (r_div_cnt == CNT_LAST) begin
            r_div_cnt <= '0;
        end else begin
            r_div_cnt <= r_div_cnt + CW'(1);
        end
    end

    // ad_clk is high in the first half of the period so the tick lands late in the low phase.
    assign ad_clk = (r_div_cnt < CNT_HALF);
    assign tick   = (r_div_cnt == CNT_LAST);

endmodule

// File: rtl/ad_frame_ctrl.sv
// Frames ADC samples into FRAME_LEN-long valid/ready bursts with sop/eop for the FFT.
// Build option: define AD_FRAME_SIGNED_EN to convert offset-binary samples to two's complement.
module ad_frame_ctrl
    import ad_fft_pkg::*;
#(
    parameter int FRAME_LEN  = FFT_FRAME_LEN,
    parameter int SAMPLE_DIV = AD_SAMPLE_DIV,
    parameter int DW         = AD_DW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          cont,
    input  logic [DW-1:0] ad_data,
    output logic          ad_clk,
    output logic          sink_valid,
    output logic          sink_sop,
    output logic          sink_eop,
    output logic [DW-1:0] sink_data,
    input  logic          sink_ready,
    output logic          busy,
    output logic          frame_done,
    output logic          overrun,
    output state_t        dbg_state
);

    localparam int IW = $clog2(FRAME_LEN);
    localparam logic [IW-1:0] IDX_LAST = IW'(FRAME_LEN - 1);

    logic          w_tick;
    logic          w_accept;
    logic [DW-1:0] w_sample;

    state_t        r_state;
    logic [IW-1:0] r_idx;
    logic          r_valid;
    logic          r_sop;
    logic          r_eop;
    logic [DW-1:0] r_data;
    logic          r_frame_done;
    logic          r_overrun;

    ad_clk_div #(
        .SAMPLE_DIV (SAMPLE_DIV)
    ) u_clk_div (
        .clk    (clk),
        .rst_n  (rst_n),
        .ad_clk (ad_clk),
        .tick   (w_tick)
    );

`ifdef AD_FRAME_SIGNED_EN
    assign w_sample = {~ad_data[DW-1], ad_data[DW-2:0]};
`else
    assign w_sample = ad_data;
`endif

    assign w_accept = r_valid && sink_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_idx        <= '0;
            r_valid      <= 1'b0;
            r_sop        <= 1'b0;
            r_eop        <= 1'b0;
            r_data       <= '0;
            r_frame_done <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            // A load on the same edge below overrides this clear.
            if (w_accept) begin
                r_valid <= 1'b0;
            end
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state   <= CAPTURE;
                        r_idx     <= '0;
                        r_overrun <= 1'b0;
                    end
                end
                CAPTURE: begin
                    if (w_tick) begin
                        if (r_valid && !sink_ready) begin
                            // Previous sample never left: abandon the frame.
                            r_overrun <= 1'b1;
                            r_valid   <= 1'b0;
                            r_state   <= IDLE;
                            r_idx     <= '0;
                        end else begin
                            r_data  <= w_sample;
                            r_valid <= 1'b1;
                            r_sop   <= (r_idx == '0);
                            r_eop   <= (r_idx == IDX_LAST);
                            if (r_idx == IDX_LAST) begin
                                r_idx   <= '0;
                                r_state <= DRAIN;
                            end else begin
                                r_idx <= r_idx + IW'(1);
                            end
                        end
                    end
                end
                DRAIN: begin
                    if (w_accept && r_eop) begin
                        r_frame_done <= 1'b1;
                        r_idx        <= '0;
                        r_state      <= cont ? CAPTURE : IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign sink_valid = r_valid;
    assign sink_sop   = r_sop;
    assign sink_eop   = r_eop;
    assign sink_data  = r_data;
    assign busy       = (r_state != IDLE);
    assign frame_done = r_frame_done;
    assign overrun    = r_overrun;
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_ad_frame_ctrl.sv
// Directed bench for ad_frame_ctrl with FRAME_LEN=8, SAMPLE_DIV=4, DW=16.
// Expected samples follow AD_FRAME_SIGNED_EN when it is defined for the build.
module tb_ad_frame_ctrl;
    import ad_fft_pkg::*;

    localparam int FL = 8;
    localparam int SD = 4;
    localparam int DW = 16;

    logic          clk        = 1'b0;
    logic          rst_n      = 1'b0;
    logic          start      = 1'b0;
    logic          cont       = 1'b0;
    logic          sink_ready = 1'b1;
    logic [DW-1:0] ad_data    = '0;
    logic          ad_clk;
    logic          sink_valid;
    logic          sink_sop;
    logic          sink_eop;
    logic [DW-1:0] sink_data;
    logic          busy;
    logic          frame_done;
    logic          overrun;
    state_t        dbg_state;

    ad_frame_ctrl #(
        .FRAME_LEN  (FL),
        .SAMPLE_DIV (SD),
        .DW         (DW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .cont       (cont),
        .ad_data    (ad_data),
        .ad_clk     (ad_clk),
        .sink_valid (sink_valid),
        .sink_sop   (sink_sop),
        .sink_eop   (sink_eop),
        .sink_data  (sink_data),
        .sink_ready (sink_ready),
        .busy       (busy),
        .frame_done (frame_done),
        .overrun    (overrun),
        .dbg_state  (dbg_state)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int n_done   = 0;
    int done_cyc = -1;
    bit done_busy;
    int stall;

    logic [DW-1:0] exp_q[$];
    bit            beat_sop[$];
    bit            beat_eop[$];
    int            beat_cyc[$];

    bit            chk_stable = 1'b0;
    bit            held_v     = 1'b0;
    logic [DW-1:0] held_d;
    bit            held_sop;
    bit            held_eop;

    bit            use_tab = 1'b0;
    logic [15:0]   tab[8] = '{16'h8000, 16'h0000, 16'hFFFF, 16'h7FFF,
                              16'h1234, 16'h8001, 16'h00FF, 16'hFF00};
`ifdef AD_FRAME_SIGNED_EN
    logic [15:0]   tab_exp[8] = '{16'h0000, 16'h8000, 16'h7FFF, 16'hFFFF,
                                  16'h9234, 16'h0001, 16'h80FF, 16'h7F00};
`else
    logic [15:0]   tab_exp[8] = '{16'h8000, 16'h0000, 16'hFFFF, 16'h7FFF,
                                  16'h1234, 16'h8001, 16'h00FF, 16'hFF00};
`endif

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Offset-binary ramps flip only the MSB in the signed build.
    function automatic logic [15:0] ramp_exp(input logic [15:0] x);
`ifdef AD_FRAME_SIGNED_EN
        return x ^ 16'h8000;
`else
        return x;
`endif
    endfunction

    // Observe the current cycle (inputs already set), then advance one clock.
    task automatic step();
        bit acc;
        acc = sink_valid && sink_ready;
        if (acc) begin
            check_eq("beat_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) check_eq("beat_data", sink_data, exp_q.pop_front());
            beat_sop.push_back(sink_sop);
            beat_eop.push_back(sink_eop);
            beat_cyc.push_back(cyc);
        end
        if (chk_stable && held_v) begin
            check_eq("stall_valid", sink_valid, 1);
            check_eq("stall_data", sink_data, held_d);
            check_eq("stall_sop", sink_sop, held_sop);
            check_eq("stall_eop", sink_eop, held_eop);
        end
        held_v   = sink_valid && !sink_ready;
        held_d   = sink_data;
        held_sop = sink_sop;
        held_eop = sink_eop;
        if (frame_done) begin
            n_done++;
            done_cyc  = cyc;
            done_busy = busy;
        end
        @(posedge clk);
        #1;
        cyc++;
        if (use_tab) ad_data = tab[beat_sop.size() % 8];
        else if (acc) ad_data = ad_data + 16'd1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic clear_log();
        exp_q.delete();
        beat_sop.delete();
        beat_eop.delete();
        beat_cyc.delete();
        n_done   = 0;
        done_cyc = -1;
        held_v   = 1'b0;
    endtask

    task automatic push_ramp(input logic [15:0] base);
        for (int k = 0; k < FL; k++) exp_q.push_back(ramp_exp(base + 16'(k)));
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic check_positions(input int n_frames);
        for (int i = 0; i < beat_sop.size(); i++) begin
            check_eq("pos_sop", beat_sop[i], (i % FL) == 0);
            check_eq("pos_eop", beat_eop[i], (i % FL) == FL - 1);
        end
        check_eq("pos_count", beat_sop.size(), n_frames * FL);
    endtask

    initial begin
        // Reset values
        #1;
        run(3);
        check_eq("rst_ad_clk", ad_clk, 1);
        check_eq("rst_valid", sink_valid, 0);
        check_eq("rst_sop", sink_sop, 0);
        check_eq("rst_eop", sink_eop, 0);
        check_eq("rst_data", sink_data, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", frame_done, 0);
        check_eq("rst_overrun", overrun, 0);
        check_eq("rst_state", dbg_state, IDLE);

        // ad_clk: 2 high, 2 low, starting from div_cnt=0
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check_eq("ad_clk_phase", ad_clk, (i % 4) < 2);
            step();
        end

        // Single shot
        clear_log();
        ad_data = 16'h0100;
        push_ramp(16'h0100);
        pulse_start();
        check_eq("ss_busy", busy, 1);
        run(45);
        check_positions(1);
        check_eq("ss_done", n_done, 1);
        if (beat_cyc.size() > 0) check_eq("ss_done_lat", done_cyc, beat_cyc[beat_cyc.size()-1] + 1);
        check_eq("ss_done_busy", done_busy, 0);
        check_eq("ss_busy_end", busy, 0);
        check_eq("ss_overrun", overrun, 0);
        check_eq("ss_sb_empty", exp_q.size(), 0);
        run(12);
        check_eq("ss_no_more", beat_sop.size(), FL);
        check_eq("ss_valid_end", sink_valid, 0);

        // Continuous, dropped during frame 3
        clear_log();
        ad_data = 16'h0100;
        push_ramp(16'h0100);
        push_ramp(16'h0108);
        push_ramp(16'h0110);
        cont = 1'b1;
        pulse_start();
        for (int i = 0; i < 150 && n_done < 2; i++) step();
        check_eq("ct_wait2", n_done, 2);
        check_eq("ct_busy_mid", busy, 1);
        cont = 1'b0;
        run(50);
        check_positions(3);
        check_eq("ct_done", n_done, 3);
        if (beat_cyc.size() >= 3 * FL) begin
            check_eq("ct_gap1", beat_cyc[FL] - beat_cyc[FL-1], SD);
            check_eq("ct_gap2", beat_cyc[2*FL] - beat_cyc[2*FL-1], SD);
        end
        check_eq("ct_busy_end", busy, 0);
        check_eq("ct_sb_empty", exp_q.size(), 0);

        // Backpressure: 2 stalled cycles per beat
        clear_log();
        ad_data = 16'h0100;
        push_ramp(16'h0100);
        chk_stable = 1'b1;
        stall = 0;
        pulse_start();
        for (int i = 0; i < 70; i++) begin
            if (sink_valid && stall < 2) begin
                sink_ready = 1'b0;
                stall++;
            end else begin
                sink_ready = 1'b1;
                if (sink_valid) stall = 0;
            end
            step();
        end
        chk_stable = 1'b0;
        sink_ready = 1'b1;
        check_positions(1);
        check_eq("bp_overrun", overrun, 0);
        check_eq("bp_done", n_done, 1);
        check_eq("bp_sb_empty", exp_q.size(), 0);

        // Overrun at beat 3
        clear_log();
        ad_data = 16'h0100;
        push_ramp(16'h0100);
        stall = 0;
        pulse_start();
        for (int i = 0; i < 80 && !overrun; i++) begin
            if (beat_sop.size() == 3 && sink_valid) begin
                sink_ready = 1'b0;
                stall++;
            end else begin
                sink_ready = 1'b1;
            end
            step();
        end
        check_eq("ov_set", overrun, 1);
        check_eq("ov_latency", stall, SD);
        check_eq("ov_valid", sink_valid, 0);
        check_eq("ov_busy", busy, 0);
        check_eq("ov_state", dbg_state, IDLE);
        sink_ready = 1'b0;
        step();
        sink_ready = 1'b1;
        run(10);
        check_eq("ov_no_done", n_done, 0);
        check_eq("ov_beats", beat_sop.size(), 3);
        check_eq("ov_sticky", overrun, 1);
        clear_log();
        ad_data = 16'h0200;
        push_ramp(16'h0200);
        pulse_start();
        check_eq("ov_clear", overrun, 0);
        run(45);
        check_positions(1);
        check_eq("ov_clean_done", n_done, 1);
        check_eq("ov_clean_ovr", overrun, 0);
        check_eq("ov_sb_empty", exp_q.size(), 0);

        // Reset mid-frame at beat 4
        clear_log();
        ad_data = 16'h0100;
        push_ramp(16'h0100);
        pulse_start();
        for (int i = 0; i < 80 && !(sink_valid && beat_sop.size() == 4); i++) step();
        check_eq("rm_reach", beat_sop.size(), 4);
        rst_n = 1'b0;
        sink_ready = 1'b0;
        step();
        check_eq("rm_ad_clk", ad_clk, 1);
        check_eq("rm_valid", sink_valid, 0);
        check_eq("rm_sop", sink_sop, 0);
        check_eq("rm_eop", sink_eop, 0);
        check_eq("rm_data", sink_data, 0);
        check_eq("rm_busy", busy, 0);
        check_eq("rm_done", frame_done, 0);
        check_eq("rm_overrun", overrun, 0);
        check_eq("rm_state", dbg_state, IDLE);
        rst_n = 1'b1;
        sink_ready = 1'b1;
        clear_log();
        ad_data = 16'h0300;
        push_ramp(16'h0300);
        pulse_start();
        run(45);
        check_positions(1);
        check_eq("rm_after_done", n_done, 1);
        check_eq("rm_sb_empty", exp_q.size(), 0);

        // Sample format table
        clear_log();
        use_tab = 1'b1;
        ad_data = tab[0];
        for (int k = 0; k < FL; k++) exp_q.push_back(tab_exp[k]);
        pulse_start();
        run(45);
        use_tab = 1'b0;
        check_positions(1);
        check_eq("fmt_done", n_done, 1);
        check_eq("fmt_sb_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ad_frame_ctrl.md
# ad_frame_ctrl

Sequences ADC capture into fixed-length frames for the FFT core. Generates the ADC sample clock and an internal sample tick, registers one ADC word per tick, and presents it on a valid/ready stream with start-of-frame and end-of-frame markers. Sits between the ADC capture register and the FFT sink port. Supports single-shot and continuous framing, with a sticky overrun error.

## Interface
- FRAME_LEN, 1024: samples per frame, ≥2.
- SAMPLE_DIV, 50: clk cycles per sample, even, ≥4.
- DW, 16: sample width.
- clk  in  1  system clock, sole clock of the block.
- rst_n  in  1  reset, synchronous, active-low.
- start  in  1  one-cycle pulse; arms a frame when idle.
- cont  in  1  continuous mode; sampled when each eop is accepted.
- ad_data  in  DW  ADC word, already stable in the clk domain at each tick.
- ad_clk  out  1  ADC sample clock: high for div_cnt < SAMPLE_DIV/2, otherwise low.
- sink_valid  out  1  stream valid.
- sink_sop  out  1  first sample of the frame; qualified by sink_valid.
- sink_eop  out  1  last sample of the frame; qualified by sink_valid.
- sink_data  out  DW  sample.
- sink_ready  in  1  FFT accepts the sample when valid && ready.
- busy  out  1  high in CAPTURE or DRAIN.
- frame_done  out  1  one-cycle pulse when eop is accepted.
- overrun  out  1  sticky error; cleared by an accepted start or by reset.

## Operation
- div_cnt runs free, 0..SAMPLE_DIV-1, wrapping to 0. tick = (div_cnt == SAMPLE_DIV-1). The counter never stops outside reset.
- States:
  - IDLE: start → CAPTURE. idx=0. overrun cleared.
  - CAPTURE: on each tick, load sink_data and set sink_valid. sop=(idx==0), eop=(idx==FRAME_LEN-1). Then idx++. When the tick loads idx==FRAME_LEN-1 → DRAIN.
  - DRAIN: wait for valid && ready with eop set. Then pulse frame_done and go to CAPTURE if cont (idx=0), otherwise IDLE.
- sink_valid stays high until accepted. sink_data/sop/eop stay stable while valid && !ready.
- Overrun: a tick in CAPTURE while sink_valid && !sink_ready:
  - overrun is set, sink_valid is cleared, state → IDLE, and no frame_done pulse.
  - The FFT sees a truncated frame; upper logic discards it on overrun.
- A tick in the same cycle as an acceptance is not an overrun. The new sample loads on that edge.
- start while busy is ignored. start and tick in the same cycle: the first sample is taken at the next tick.
- Index counter width is $clog2(FRAME_LEN). Wrap is explicit at FRAME_LEN-1, so FRAME_LEN need not be a power of 2.
- Reset mid-frame: on the next clk edge with rst_n low, state=IDLE and all counters are 0. The partial frame is lost.

## Timing
- Reset values: ad_clk=1 (div_cnt=0), sink_valid=0, sink_sop=0, sink_eop=0, sink_data=0, busy=0, frame_done=0, overrun=0.
- Tick-to-valid latency: 1 cycle. ad_data is captured at the edge ending the tick cycle, and sink_valid is high in the following cycle.
- The first sample after start arrives 1..SAMPLE_DIV cycles later, depending on div_cnt phase.
- frame_done is high in the cycle after the eop acceptance edge.
- busy drops in the same cycle frame_done rises (single-shot) or on the overrun edge.
- In continuous mode there are no gaps: the next sop is the first tick after eop is accepted.

## Configuration
- AD_FRAME_SIGNED_EN defined: sink_data = {~ad_data[DW-1], ad_data[DW-2:0]}. This converts offset-binary ADC output to two's complement for the FFT.
- AD_FRAME_SIGNED_EN undefined: sink_data = ad_data unchanged.
- Timing and handshake behaviour are identical in both builds.

## Structure
- Shared package ad_fft_pkg holds:
  - the state enum (IDLE, CAPTURE, DRAIN);
  - default constants FFT_FRAME_LEN=1024, AD_SAMPLE_DIV=50, AD_DW=16.
- One sub-module, ad_clk_div: contains div_cnt and drives ad_clk and tick. Parameter SAMPLE_DIV; ports clk and rst_n.
- The FSM, index counter, stream register and flags live in ad_frame_ctrl.

## Test plan
Bench uses FRAME_LEN=8, SAMPLE_DIV=4, ready tied high unless stated.
- Single shot: start; ad_data = ramp 0x0100+k → 8 beats; sop on 0x0100, eop on 0x0107; one frame_done; busy low afterwards; no further valid.
- Continuous: cont=1 and start → 3 back-to-back frames, each sop exactly 4 cycles after the previous eop. Drop cont during frame 3 → stops after its eop.
- Backpressure: ready low for 2 cycles per beat (less than 4) → no overrun; data holds stable while stalled; all 8 beats delivered in order.
- Overrun: ready low for 5 cycles at beat 3 → overrun=1, valid=0, busy=0, no frame_done. The next start clears overrun and runs a clean frame.
- Reset mid-frame: rst_n low for 1 cycle at beat 4 → all outputs at reset values the next cycle; start is accepted afterwards.
- AD_FRAME_SIGNED_EN: ad_data 0x8000 → sink_data 0x0000; 0x0000 → 0x8000; 0xFFFF → 0x7FFF. Without the macro these pass through unchanged.
